// File: rtl/game_flow_controller_pkg.sv
// Shared definitions for the FlappyBox game sequencer: state encoding and small helpers.
// The encoding is also consumed by display_top/renderer, so values are fixed.
package game_flow_controller_pkg;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_PLAYING  = 3'd2,
    ST_GAMEOVER = 3'd3,
    ST_HIT      = 3'd4,
    ST_PAUSED   = 3'd5
  } game_state_e;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_flow_controller_if.sv
// Button/collision inputs and renderer-facing outputs of the game sequencer.
// master = sequencer side, slave = environment (debouncers, collision detector, renderer).
interface game_flow_controller_if #(
  parameter int LIFE_W = 2
);
  logic              start;
  logic              up;
  logic              collision;
  logic [2:0]        game_state;
  logic              game_en;
  logic              game_reset;
  logic [LIFE_W-1:0] lives;

  modport master (
    input  start, up, collision,
    output game_state, game_en, game_reset, lives
  );

  modport slave (
    output start, up, collision,
    input  game_state, game_en, game_reset, lives
  );
endinterface

// File: rtl/game_flow_controller_rise_edge.sv
// 1-bit rising-edge detector: pulse while the level is high and was low last cycle,
// so a held button produces exactly one event.
module rise_edge (
  input  logic clk,
  input  logic hard_reset_n,
  input  logic i_level,
  output logic o_pe
);
  logic r_levelQ;

  always_ff @(posedge clk or negedge hard_reset_n) begin
    if (!hard_reset_n) r_levelQ <= 1'b0;
    else               r_levelQ <= i_level;
  end

  assign o_pe = i_level & ~r_levelQ;
endmodule

// File: rtl/game_flow_controller.sv
// FlappyBox game sequencer: INIT -> IDLE -> PLAYING (-> HIT grace) -> GAMEOVER with multiple lives.
// Optional pause (start button in PLAYING/HIT) is enabled by defining FLAPPY_PAUSE_EN.
module game_flow_controller
  import game_flow_controller_pkg::*;
#(
  parameter int INIT_TICKS  = 20_000_000,
  parameter int LIVES       = 3,
  parameter int GRACE_TICKS = 50_000_000
) (
  input logic               clk,
  input logic               hard_reset_n,
  game_flow_controller_if.master bus
);
  localparam int TIMER_W = $clog2(maxInt(INIT_TICKS, GRACE_TICKS) + 1);
  localparam int LIFE_W  = $clog2(LIVES + 1);
  localparam logic [TIMER_W-1:0] INIT_LOAD  = TIMER_W'(INIT_TICKS - 1);
  localparam logic [TIMER_W-1:0] GRACE_LOAD = TIMER_W'(GRACE_TICKS - 1);
  localparam logic [LIFE_W-1:0]  LIVES_LOAD = LIFE_W'(LIVES);

  game_state_e        r_state, w_state;
  logic [TIMER_W-1:0] r_timer, w_timer;
  logic [LIFE_W-1:0]  r_lives, w_lives;
  logic               r_gameEn, w_gameEn;
  logic               r_gameReset, w_gameReset;
  logic               w_startPe, w_upPe;
`ifdef FLAPPY_PAUSE_EN
  logic               r_retHit, w_retHit;
`endif

  rise_edge u_startEdge (
    .clk          (clk),
    .hard_reset_n (hard_reset_n),
    .i_level      (bus.start),
    .o_pe         (w_startPe)
  );

  rise_edge u_upEdge (
    .clk          (clk),
    .hard_reset_n (hard_reset_n),
    .i_level      (bus.up),
    .o_pe         (w_upPe)
  );

  always_ff @(posedge clk or negedge hard_reset_n) begin
    if (!hard_reset_n) begin
      r_state     <= ST_INIT;
      r_timer     <= INIT_LOAD;
      r_lives     <= '0;
      r_gameEn    <= 1'b0;
      r_gameReset <= 1'b0;
`ifdef FLAPPY_PAUSE_EN
      r_retHit    <= 1'b0;
`endif
    end else begin
      r_state     <= w_state;
      r_timer     <= w_timer;
      r_lives     <= w_lives;
      r_gameEn    <= w_gameEn;
      r_gameReset <= w_gameReset;
`ifdef FLAPPY_PAUSE_EN
      r_retHit    <= w_retHit;
`endif
    end
  end

  // Collision outranks a pause request in PLAYING; the dropped start edge is not remembered.
  always_comb begin
    w_state     = r_state;
    w_timer     = r_timer;
    w_lives     = r_lives;
    w_gameEn    = r_gameEn;
    w_gameReset = 1'b0;
`ifdef FLAPPY_PAUSE_EN
    w_retHit    = r_retHit;
`endif
    case (r_state)
      ST_INIT: begin
        w_gameEn = 1'b0;
        if (r_timer == '0) w_state = ST_IDLE;
        else               w_timer = r_timer - TIMER_W'(1);
      end
      ST_IDLE: begin
        if (w_upPe) begin
          w_state     = ST_PLAYING;
          w_gameEn    = 1'b1;
          w_lives     = LIVES_LOAD;
          w_gameReset = 1'b1;
        end
      end
      ST_PLAYING: begin
        if (bus.collision) begin
          if (r_lives > LIFE_W'(1)) begin
            w_lives = r_lives - LIFE_W'(1);
            w_state = ST_HIT;
            w_timer = GRACE_LOAD;
          end else begin
            w_lives  = '0;
            w_state  = ST_GAMEOVER;
            w_gameEn = 1'b0;
          end
        end
`ifdef FLAPPY_PAUSE_EN
        else if (w_startPe) begin
          w_state  = ST_PAUSED;
          w_gameEn = 1'b0;
          w_retHit = 1'b0;
        end
`endif
      end
      ST_HIT: begin
`ifdef FLAPPY_PAUSE_EN
        if (w_startPe) begin
          w_state  = ST_PAUSED;
          w_gameEn = 1'b0;
          w_retHit = 1'b1;
        end else
`endif
        if (r_timer == '0) w_state = ST_PLAYING;
        else               w_timer = r_timer - TIMER_W'(1);
      end
      ST_GAMEOVER: begin
        w_gameEn = 1'b0;
        if (w_startPe) begin
          w_state     = ST_INIT;
          w_timer     = INIT_LOAD;
          w_gameReset = 1'b1;
        end
      end
`ifdef FLAPPY_PAUSE_EN
      ST_PAUSED: begin
        if (w_startPe) begin
          w_state  = r_retHit ? ST_HIT : ST_PLAYING;
          w_gameEn = 1'b1;
        end
      end
`endif
      default: begin
        w_state  = ST_INIT;
        w_timer  = INIT_LOAD;
        w_gameEn = 1'b0;
      end
    endcase
  end

  always_comb begin
    bus.game_state = r_state;
    bus.game_en    = r_gameEn;
    bus.game_reset = r_gameReset;
    bus.lives      = r_lives;
  end
endmodule

// File: tb/tb_game_flow_controller.sv
// Self-checking bench for game_flow_controller: directed scenarios plus random play,
// each cycle compared against a cycle-count model of the game rules (pause checks when FLAPPY_PAUSE_EN is defined).
module tb_game_flow_controller;
  import game_flow_controller_pkg::*;

  localparam int INIT_TICKS  = 4;
  localparam int LIVES       = 3;
  localparam int GRACE_TICKS = 3;
  localparam int LIFE_W      = 2;

  logic clk = 1'b0;
  logic hard_reset_n = 1'b0;
  int   nChecks = 0;
  int   nFails  = 0;

  game_flow_controller_if #(.LIFE_W(LIFE_W)) bus();

  game_flow_controller #(
    .INIT_TICKS  (INIT_TICKS),
    .LIVES       (LIVES),
    .GRACE_TICKS (GRACE_TICKS)
  ) dut (
    .clk          (clk),
    .hard_reset_n (hard_reset_n),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // Reference model: mLeft counts the cycles still to be spent in INIT or HIT.
  int mState, mLeft, mLives, mResume;
  bit mEn, mRst, mPrevS, mPrevU;

  task automatic modelReset();
    mState = ST_INIT; mLeft = INIT_TICKS; mLives = 0; mResume = ST_PLAYING;
    mEn = 0; mRst = 0; mPrevS = 0; mPrevU = 0;
  endtask

  task automatic modelStep(input bit s, input bit u, input bit c);
    bit sPe, uPe;
    sPe = s && !mPrevS;
    uPe = u && !mPrevU;
    mPrevS = s; mPrevU = u; mRst = 0;
    case (mState)
      ST_INIT: begin
        mLeft--;
        if (mLeft == 0) mState = ST_IDLE;
      end
      ST_IDLE: if (uPe) begin
        mState = ST_PLAYING; mEn = 1; mLives = LIVES; mRst = 1;
      end
      ST_PLAYING: begin
        if (c) begin
          mLives--;
          if (mLives == 0) begin mState = ST_GAMEOVER; mEn = 0; end
          else begin mState = ST_HIT; mLeft = GRACE_TICKS; end
        end
`ifdef FLAPPY_PAUSE_EN
        else if (sPe) begin mResume = ST_PLAYING; mState = ST_PAUSED; mEn = 0; end
`endif
      end
      ST_HIT: begin
`ifdef FLAPPY_PAUSE_EN
        if (sPe) begin mResume = ST_HIT; mState = ST_PAUSED; mEn = 0; end
        else
`endif
        begin
          mLeft--;
          if (mLeft == 0) mState = ST_PLAYING;
        end
      end
      ST_GAMEOVER: if (sPe) begin
        mState = ST_INIT; mLeft = INIT_TICKS; mRst = 1;
      end
      ST_PAUSED: if (sPe) begin
        mState = mResume; mEn = 1;
      end
      default: mState = ST_INIT;
    endcase
  endtask

  function automatic logic [6:0] expVec();
    logic [2:0] st;
    logic [1:0] lv;
    st = mState[2:0];
    lv = mLives[1:0];
    return {st, mEn, mRst, lv};
  endfunction

  function automatic logic [6:0] obsVec();
    return {bus.game_state, bus.game_en, bus.game_reset, bus.lives};
  endfunction

  task automatic tick(input bit s, input bit u, input bit c);
    bus.start = s; bus.up = u; bus.collision = c;
    @(posedge clk);
    modelStep(s, u, c);
    #1;
  endtask

  task automatic freshGame();
    bus.start = 0; bus.up = 0; bus.collision = 0;
    hard_reset_n = 0;
    modelReset();
    @(negedge clk);
    hard_reset_n = 1;
    for (int i = 0; i < INIT_TICKS + 2 && mState != ST_IDLE; i++) tick(0, 0, 0);
    tick(0, 1, 0);
    tick(0, 0, 0);
    nChecks++;
    if (bus.game_state !== 3'(ST_PLAYING)) begin
      nFails++;
      $display("[TB] FAIL fresh_game: state %0d, required %0d", bus.game_state, ST_PLAYING);
    end
  endtask

  task automatic test_reset();
    int initCount;
    int pulses;
    bus.start = 0; bus.up = 0; bus.collision = 0;
    hard_reset_n = 0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    nChecks++;
    if (obsVec() !== 7'b000_0_0_00) begin
      nFails++;
      $display("[TB] FAIL reset_values: got %b required %b", obsVec(), 7'b000_0_0_00);
    end
    @(negedge clk);
    hard_reset_n = 1;
    #1;
    initCount = (bus.game_state == 3'd0) ? 1 : 0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 0);
      if (bus.game_state == 3'd0) initCount++;
      if (bus.game_reset) pulses++;
      nChecks++;
      if (obsVec() !== expVec()) begin
        nFails++;
        $display("[TB] FAIL init_walk c%0d: got %b required %b", i, obsVec(), expVec());
      end
    end
    nChecks++;
    if (initCount != INIT_TICKS || pulses != 0 || bus.game_state !== 3'd1) begin
      nFails++;
      $display("[TB] FAIL init_length: init cycles %0d pulses %0d state %0d, required %0d 0 1",
               initCount, pulses, bus.game_state, INIT_TICKS);
    end
  endtask

  task automatic test_start_game();
    int pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick(0, 1, 0);
      if (bus.game_reset) pulses++;
      nChecks++;
      if (obsVec() !== expVec()) begin
        nFails++;
        $display("[TB] FAIL start_game c%0d: got %b required %b", i, obsVec(), expVec());
      end
    end
    tick(0, 0, 0);
    nChecks++;
    if (pulses != 1 || bus.game_state !== 3'd2 || bus.game_en !== 1'b1 || bus.lives !== 2'd3) begin
      nFails++;
      $display("[TB] FAIL start_game_final: pulses %0d state %0d en %0d lives %0d, required 1 2 1 3",
               pulses, bus.game_state, bus.game_en, bus.lives);
    end
  endtask

  task automatic test_collision_grace();
    int hitCount = 0;
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, (i < 4));
      if (bus.game_state == 3'd4) hitCount++;
      nChecks++;
      if (obsVec() !== expVec()) begin
        nFails++;
        $display("[TB] FAIL collision_grace c%0d: got %b required %b", i, obsVec(), expVec());
      end
    end
    nChecks++;
    if (hitCount != GRACE_TICKS || bus.lives !== 2'd2 || bus.game_state !== 3'd2) begin
      nFails++;
      $display("[TB] FAIL grace_length: hit cycles %0d lives %0d state %0d, required %0d 2 2",
               hitCount, bus.lives, bus.game_state, GRACE_TICKS);
    end
  endtask

  task automatic test_game_over();
    int pulses = 0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 6; i++) begin
        tick(0, 0, (i == 0));
        nChecks++;
        if (obsVec() !== expVec()) begin
          nFails++;
          $display("[TB] FAIL game_over k%0d c%0d: got %b required %b", k, i, obsVec(), expVec());
        end
      end
    end
    nChecks++;
    if (bus.game_state !== 3'd3 || bus.game_en !== 1'b0 || bus.lives !== 2'd0) begin
      nFails++;
      $display("[TB] FAIL game_over_final: state %0d en %0d lives %0d, required 3 0 0",
               bus.game_state, bus.game_en, bus.lives);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1, 0, 0);
      if (bus.game_reset) pulses++;
      nChecks++;
      if (obsVec() !== expVec()) begin
        nFails++;
        $display("[TB] FAIL restart c%0d: got %b required %b", i, obsVec(), expVec());
      end
    end
    nChecks++;
    if (pulses != 1 || bus.game_state !== 3'd0) begin
      nFails++;
      $display("[TB] FAIL restart_final: pulses %0d state %0d, required 1 0", pulses, bus.game_state);
    end
  endtask

`ifdef FLAPPY_PAUSE_EN
  task automatic test_pause();
    int hitAfter = 0;
    freshGame();
    tick(0, 0, 1);
    tick(0, 0, 0);
    tick(1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      tick(1, 0, ($urandom_range(0, 3) == 0));
      nChecks++;
      if (obsVec() !== expVec() || bus.game_state !== 3'd5 || bus.game_en !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL pause_hold c%0d: got %b required %b", i, obsVec(), expVec());
      end
    end
    tick(0, 0, 0);
    tick(1, 0, 0);
    for (int i = 0; i < 8 && bus.game_state == 3'd4; i++) begin
      hitAfter++;
      tick(0, 0, 0);
      nChecks++;
      if (obsVec() !== expVec()) begin
        nFails++;
        $display("[TB] FAIL pause_resume c%0d: got %b required %b", i, obsVec(), expVec());
      end
    end
    nChecks++;
    if (hitAfter != GRACE_TICKS - 1 || bus.game_state !== 3'd2) begin
      nFails++;
      $display("[TB] FAIL pause_remaining: hit cycles %0d state %0d, required %0d 2",
               hitAfter, bus.game_state, GRACE_TICKS - 1);
    end
  endtask
`else
  task automatic test_start_ignored();
    freshGame();
    for (int i = 0; i < 4; i++) begin
      tick((i % 2) == 0, 0, 0);
      nChecks++;
      if (obsVec() !== expVec() || bus.game_state !== 3'd2) begin
        nFails++;
        $display("[TB] FAIL start_ignored c%0d: got %b required %b", i, obsVec(), expVec());
      end
    end
  endtask
`endif

  task automatic test_simultaneous();
    freshGame();
    tick(1, 0, 1);
    nChecks++;
    if (obsVec() !== expVec() || bus.game_state !== 3'd4) begin
      nFails++;
      $display("[TB] FAIL simul_hit: got %b required %b", obsVec(), expVec());
    end
    for (int i = 0; i < 4; i++) tick(0, 0, 0);
    tick(0, 0, 1);
    for (int i = 0; i < 4; i++) tick(0, 0, 0);
    tick(1, 0, 1);
    nChecks++;
    if (obsVec() !== expVec() || bus.game_state !== 3'd3) begin
      nFails++;
      $display("[TB] FAIL simul_last_life: got %b required %b", obsVec(), expVec());
    end
  endtask

  task automatic test_reset_mid_hit();
    freshGame();
    tick(0, 0, 1);
    #2;
    hard_reset_n = 0;
    modelReset();
    #1;
    nChecks++;
    if (obsVec() !== 7'b000_0_0_00) begin
      nFails++;
      $display("[TB] FAIL reset_mid_hit: got %b required %b", obsVec(), 7'b000_0_0_00);
    end
    bus.collision = 0;
    @(negedge clk);
    hard_reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0);
      nChecks++;
      if (obsVec() !== expVec()) begin
        nFails++;
        $display("[TB] FAIL after_reset c%0d: got %b required %b", i, obsVec(), expVec());
      end
    end
  endtask

  task automatic test_random();
    bit s, u, c;
    s = 0; u = 0; c = 0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 2) == 0) s = ~s;
      if ($urandom_range(0, 2) == 0) u = ~u;
      c = ($urandom_range(0, 5) == 0);
      tick(s, u, c);
      nChecks++;
      if (obsVec() !== expVec()) begin
        nFails++;
        $display("[TB] FAIL random c%0d: got %b required %b", i, obsVec(), expVec());
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_start_game();
    test_collision_grace();
    test_game_over();
`ifdef FLAPPY_PAUSE_EN
    test_pause();
`else
    test_start_ignored();
`endif
    test_simultaneous();
    test_reset_mid_hit();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
